// File: rtl/spi_pll_lock_ctrl.sv
// Reset/lock sequencer for the SPI PLL: holds the PLL in reset, qualifies its locked flag
// and grants clk_ready_o only after lock has been stable; retries a bounded number of times.
module spi_pll_lock_ctrl #(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic       clk_ready_o,
    output logic       lock_lost_o,
    output logic       fail_o,
    output logic [2:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_ASSERT_RST = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_READY      = 3'd3,
        S_FAIL       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_STAB_DONE = CNT_W'(LOCK_STABLE_CYC);
    localparam logic [2:0]       C_MAX_RETRY = 3'(MAX_RETRY);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_stab;
    logic [2:0]       r_retry;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_pll_rst;
    logic             r_clk_ready;
    logic             r_lock_lost;
    logic             r_fail;

    state_t           w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic [CNT_W-1:0] w_stab_n;
    logic [2:0]       w_retry_n;
    logic [2:0]       w_retry_inc;
    logic             w_lock_lost_n;
    logic             w_timeout;
    logic             w_do_timeout;
    logic             w_lk;

    assign w_lk = r_sync2;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ASSERT_RST;
            r_cnt       <= '0;
            r_stab      <= '0;
            r_retry     <= 3'd0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_pll_rst   <= 1'b1;
            r_clk_ready <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_stab      <= w_stab_n;
            r_retry     <= w_retry_n;
            r_sync1     <= pll_locked_i;
            r_sync2     <= r_sync1;
            // Outputs are registered from the next state so they line up with state_o.
            r_pll_rst   <= (w_state_n == S_ASSERT_RST) || (w_state_n == S_FAIL);
            r_clk_ready <= (w_state_n == S_READY);
            r_lock_lost <= w_lock_lost_n;
            r_fail      <= (w_state_n == S_FAIL);
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_stab_n      = r_stab;
        w_retry_n     = r_retry;
        w_lock_lost_n = 1'b0;
        w_do_timeout  = 1'b0;
        w_timeout     = (r_cnt == C_TMO_LAST);
        w_retry_inc   = (r_retry == C_MAX_RETRY) ? r_retry : r_retry + 3'd1;

        case (r_state)
            S_ASSERT_RST: begin
                if (r_cnt == C_RST_LAST) begin
                    w_state_n = S_WAIT_LOCK;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (w_timeout) begin
                    w_do_timeout = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                    if (w_lk) begin
                        w_state_n = S_STABLE;
                        w_stab_n  = '0;
                    end
                end
            end
            S_STABLE: begin
                // A completed stability window beats a timeout landing on the same cycle.
                if (w_lk && (r_stab == C_STAB_DONE)) begin
                    w_state_n = S_READY;
                end else if (w_timeout) begin
                    w_do_timeout = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                    if (w_lk) begin
                        w_stab_n = r_stab + 1'b1;
                    end else begin
                        w_state_n = S_WAIT_LOCK;
                        w_stab_n  = '0;
                    end
                end
            end
            S_READY: begin
                if (relock_req_i || !w_lk) begin
                    w_state_n     = S_ASSERT_RST;
                    w_cnt_n       = '0;
                    w_retry_n     = 3'd0;
                    w_lock_lost_n = !relock_req_i;
                end
            end
            S_FAIL: begin
                if (relock_req_i) begin
                    w_state_n = S_ASSERT_RST;
                    w_cnt_n   = '0;
                    w_retry_n = 3'd0;
                end
            end
            default: begin
                w_state_n = S_ASSERT_RST;
                w_cnt_n   = '0;
                w_stab_n  = '0;
            end
        endcase

        if (w_do_timeout) begin
            w_retry_n = w_retry_inc;
            w_cnt_n   = '0;
            w_stab_n  = '0;
            w_state_n = (w_retry_inc == C_MAX_RETRY) ? S_FAIL : S_ASSERT_RST;
        end
    end

    assign pll_rst_o   = r_pll_rst;
    assign clk_ready_o = r_clk_ready;
    assign lock_lost_o = r_lock_lost;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retry;
    assign state_o     = r_state;

endmodule
